// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: receives UART bytes from rx and assembles 3-byte command
// frames (header/opcode, operand A, operand B). Each complete frame is
// presented as opcode/a/b together with a one-cycle cmd_valid strobe.
// Optional feature macro: UART_CMD_RX_PARITY_EN selects 8E1 framing
// (even parity after D7). When it is undefined the framing is 8N1.
module uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [2:0] opcode,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       cmd_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       sync_err
);
    localparam int unsigned      TMR_W     = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      TMO_LAST  = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

`ifdef UART_CMD_RX_PARITY_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif
    typedef enum logic [1:0] {AS_HDR, AS_OPA, AS_OPB} asm_state_t;

    logic             rx_meta_q, rx_sync_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
`ifdef UART_CMD_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif
    logic             byte_good, byte_bad;

    asm_state_t       asm_q, asm_d;
    logic [2:0]       hold_op_q, hold_op_d;
    logic [7:0]       hold_a_q, hold_a_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             tmo_hit;
    logic [2:0]       opcode_q, opcode_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             sync_err_q, sync_err_d;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Byte receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            tmr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
`ifdef UART_CMD_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
`ifdef UART_CMD_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // Receiver next state: sample mid-bit, flag good/bad byte at the stop sample.
    always_comb begin
        rx_state_d = rx_state_q;
        tmr_d      = tmr_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
`ifdef UART_CMD_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        byte_good  = 1'b0;
        byte_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                tmr_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d      = '0;
                    idx_d      = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            RX_DATA: begin
                if (tmr_q == FULL_LAST) begin
                    tmr_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
`ifdef UART_CMD_RX_PARITY_EN
            RX_PARITY: begin
                if (tmr_q == FULL_LAST) begin
                    tmr_d      = '0;
                    par_err_d  = rx_sync_q ^ (^shift_q);
                    rx_state_d = RX_STOP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
`endif
            RX_STOP: begin
                if (tmr_q == FULL_LAST) begin
                    tmr_d      = '0;
                    rx_state_d = RX_IDLE;
`ifdef UART_CMD_RX_PARITY_EN
                    if (rx_sync_q && !par_err_q) byte_good = 1'b1;
                    else                         byte_bad  = 1'b1;
`else
                    if (rx_sync_q) byte_good = 1'b1;
                    else           byte_bad  = 1'b1;
`endif
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame assembler, inter-byte timeout and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            asm_q       <= AS_HDR;
            hold_op_q   <= '0;
            hold_a_q    <= '0;
            tmo_q       <= '0;
            opcode_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            hold_op_q   <= hold_op_d;
            hold_a_q    <= hold_a_d;
            tmo_q       <= tmo_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Assembler next state; a completing byte takes priority over the timeout.
    always_comb begin
        asm_d       = asm_q;
        hold_op_d   = hold_op_q;
        hold_a_d    = hold_a_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        sync_err_d  = 1'b0;
        tmo_d       = (asm_q != AS_HDR) ? tmo_q + 32'd1 : 32'd0;
        tmo_hit     = (TIMEOUT_BITS != 0) && (asm_q != AS_HDR) && (tmo_q == TMO_LAST);
        if (byte_bad) begin
            frame_err_d = 1'b1;
            asm_d       = AS_HDR;
            tmo_d       = '0;
        end else if (byte_good) begin
            tmo_d = '0;
            case (asm_q)
                AS_HDR: begin
                    if (shift_q[7:3] == 5'b10100) begin
                        hold_op_d = shift_q[2:0];
                        asm_d     = AS_OPA;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                AS_OPA: begin
                    hold_a_d = shift_q;
                    asm_d    = AS_OPB;
                end
                AS_OPB: begin
                    opcode_d    = hold_op_q;
                    a_d         = hold_a_q;
                    b_d         = shift_q;
                    cmd_valid_d = 1'b1;
                    asm_d       = AS_HDR;
                end
                default: asm_d = AS_HDR;
            endcase
        end else if (tmo_hit) begin
            frame_err_d = 1'b1;
            asm_d       = AS_HDR;
            tmo_d       = '0;
        end
    end

    assign opcode    = opcode_q;
    assign a         = a_q;
    assign b         = b_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign sync_err  = sync_err_q;
    assign rx_busy   = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Testbench for uart_cmd_rx: directed frames plus randomized byte streams,
// checked against a frame-level model of the command protocol.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
    localparam int CPB = 16;
    localparam int TMO = 32;
    localparam int EV_CMD  = 0;
    localparam int EV_FERR = 1;
    localparam int EV_SERR = 2;

    typedef struct {
        int         kind;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [2:0] opcode;
    logic [7:0] a, b;
    logic       cmd_valid, rx_busy, frame_err, sync_err;

    int checks = 0;
    int errors = 0;

    // expected events, in order, and the expected held output values
    ev_t        evq[$];
    logic [2:0] exp_op = 3'd0;
    logic [7:0] exp_a  = 8'd0;
    logic [7:0] exp_b  = 8'd0;

    // frame-level model: position in frame and captured header/operand
    int         pos  = 0;
    logic [2:0] m_op = 3'd0;
    logic [7:0] m_a  = 8'd0;
    int         n_exp_cmd = 0;

    // pulse counts observed on the DUT
    int cnt_cmd = 0, cnt_ferr = 0, cnt_serr = 0;
    int cmp_kind;
    ev_t cmp_ev;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .cmd_valid (cmd_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .sync_err  (sync_err)
    );

    always #5 clock = ~clock;

    // Compare process: every pulse must match the next expected event, and
    // the held outputs must always equal the last expected command.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_op = 3'd0;
                exp_a  = 8'd0;
                exp_b  = 8'd0;
            end else if (cmd_valid || frame_err || sync_err) begin
                checks++;
                cmp_kind = cmd_valid ? EV_CMD : (frame_err ? EV_FERR : EV_SERR);
                if (cmd_valid) cnt_cmd++;
                if (frame_err) cnt_ferr++;
                if (sync_err)  cnt_serr++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: got kind %0d (op=%0h a=%0h b=%0h), expected no pulse",
                             cmp_kind, opcode, a, b);
                end else begin
                    cmp_ev = evq.pop_front();
                    if ((32'(cmd_valid) + 32'(frame_err) + 32'(sync_err)) != 1 || cmp_ev.kind != cmp_kind ||
                        (cmp_kind == EV_CMD && {opcode, a, b} !== {cmp_ev.op, cmp_ev.a, cmp_ev.b})) begin
                        errors++;
                        $display("FAIL pulse_event: got kind %0d op=%0h a=%0h b=%0h, expected kind %0d op=%0h a=%0h b=%0h",
                                 cmp_kind, opcode, a, b, cmp_ev.kind, cmp_ev.op, cmp_ev.a, cmp_ev.b);
                    end
                    if (cmp_ev.kind == EV_CMD) begin
                        exp_op = cmp_ev.op;
                        exp_a  = cmp_ev.a;
                        exp_b  = cmp_ev.b;
                    end
                end
            end
            checks++;
            if ({opcode, a, b} !== {exp_op, exp_a, exp_b}) begin
                errors++;
                $display("FAIL held_outputs: got op=%0h a=%0h b=%0h, expected op=%0h a=%0h b=%0h",
                         opcode, a, b, exp_op, exp_a, exp_b);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
        ev_t e;
        e.kind = kind;
        e.op   = op;
        e.a    = va;
        e.b    = vb;
        evq.push_back(e);
        if (kind == EV_CMD) n_exp_cmd++;
    endtask

    // Protocol rules applied to one received byte.
    task automatic model_byte(input logic [7:0] d, input bit good);
        if (!good) begin
            push_ev(EV_FERR, 3'd0, 8'd0, 8'd0);
            pos = 0;
        end else if (pos == 0) begin
            if (d[7:3] == 5'b10100) begin
                m_op = d[2:0];
                pos  = 1;
            end else begin
                push_ev(EV_SERR, 3'd0, 8'd0, 8'd0);
            end
        end else if (pos == 1) begin
            m_a = d;
            pos = 2;
        end else begin
            push_ev(EV_CMD, m_op, m_a, d);
            pos = 0;
        end
    endtask

    task automatic drain_check(input string name);
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL %s_event_missing: got %0d events outstanding, expected 0", name, evq.size());
            evq.delete();
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_cycles(CPB);
    endtask

    task automatic apply_reset();
        rx    = 1'b1;
        reset = 1'b1;
        pos   = 0;
        evq.delete();
        wait_cycles(3);
        check("reset_mid_outputs", {21'd0, opcode, a, b, cmd_valid, frame_err, sync_err, rx_busy}, 32'd0);
        reset = 1'b0;
        wait_cycles(2);
    endtask

    // Send one byte; rst_bit >= 0 aborts it with a reset in that data bit.
    task automatic send_byte(input logic [7:0] d, input bit stop_bad, input bit par_bad, input int rst_bit);
        if (rst_bit < 0) model_byte(d, !(stop_bad || par_bad));
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rx = d[i];
                wait_cycles(CPB / 2);
                apply_reset();
                return;
            end
            drive_bit(d[i]);
        end
`ifdef UART_CMD_RX_PARITY_EN
        drive_bit((^d) ^ par_bad);
`endif
        drive_bit(!stop_bad);
        rx = 1'b1;
        if (stop_bad) wait_cycles(2 * CPB);
        drain_check("byte");
    endtask

    task automatic idle_bits(input int bits);
        if (pos != 0 && bits >= TMO) begin
            push_ev(EV_FERR, 3'd0, 8'd0, 8'd0);
            pos = 0;
        end
        rx = 1'b1;
        wait_cycles(bits * CPB);
        drain_check("idle");
    endtask

    task automatic check_outputs(input string name, input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
        check(name, {13'd0, opcode, a, b}, {13'd0, op, va, vb});
    endtask

    int c0, f0, s0;
    logic [7:0] rd;
    bit         rs;
    int         r;

    initial begin
        wait_cycles(2);
        check("reset_state", {21'd0, opcode, a, b, cmd_valid, frame_err, sync_err, rx_busy}, 32'd0);
        reset = 1'b0;
        wait_cycles(4);

        // valid frame back-to-back
        c0 = cnt_cmd; f0 = cnt_ferr; s0 = cnt_serr;
        send_byte(8'hA3, 1'b0, 1'b0, -1);
        send_byte(8'h12, 1'b0, 1'b0, -1);
        send_byte(8'h34, 1'b0, 1'b0, -1);
        idle_bits(2);
        check("valid_cmd_count", cnt_cmd - c0, 1);
        check("valid_err_count", (cnt_ferr - f0) + (cnt_serr - s0), 0);
        check_outputs("valid_outputs", 3'd3, 8'h12, 8'h34);

        // bad sync header, then a good frame
        c0 = cnt_cmd; s0 = cnt_serr;
        send_byte(8'h55, 1'b0, 1'b0, -1);
        send_byte(8'hA5, 1'b0, 1'b0, -1);
        send_byte(8'hFF, 1'b0, 1'b0, -1);
        send_byte(8'h01, 1'b0, 1'b0, -1);
        idle_bits(2);
        check("sync_err_count", cnt_serr - s0, 1);
        check("sync_cmd_count", cnt_cmd - c0, 1);
        check_outputs("sync_outputs", 3'd5, 8'hFF, 8'h01);

        // stop-bit error inside a frame
        c0 = cnt_cmd; f0 = cnt_ferr;
        send_byte(8'hA1, 1'b0, 1'b0, -1);
        send_byte(8'h22, 1'b1, 1'b0, -1);
        check("ferr_count", cnt_ferr - f0, 1);
        check_outputs("ferr_hold", 3'd5, 8'hFF, 8'h01);
        send_byte(8'hA2, 1'b0, 1'b0, -1);
        send_byte(8'h10, 1'b0, 1'b0, -1);
        send_byte(8'h20, 1'b0, 1'b0, -1);
        idle_bits(2);
        check("ferr_cmd_count", cnt_cmd - c0, 1);
        check_outputs("ferr_outputs", 3'd2, 8'h10, 8'h20);

        // short glitch is a false start
        c0 = cnt_cmd; f0 = cnt_ferr; s0 = cnt_serr;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(2);
        check("glitch_busy_high", 32'(rx_busy), 1);
        wait_cycles(20);
        check("glitch_busy_low", 32'(rx_busy), 0);
        check("glitch_pulses", (cnt_cmd - c0) + (cnt_ferr - f0) + (cnt_serr - s0), 0);

        // inter-byte timeout, then a normal frame
        f0 = cnt_ferr; c0 = cnt_cmd;
        send_byte(8'hA4, 1'b0, 1'b0, -1);
        send_byte(8'h33, 1'b0, 1'b0, -1);
        idle_bits(TMO);
        check("timeout_ferr", cnt_ferr - f0, 1);
        check("timeout_no_cmd", cnt_cmd - c0, 0);
        check_outputs("timeout_hold", 3'd2, 8'h10, 8'h20);
        send_byte(8'hA0, 1'b0, 1'b0, -1);
        send_byte(8'h55, 1'b0, 1'b0, -1);
        send_byte(8'hAA, 1'b0, 1'b0, -1);
        idle_bits(2);
        check_outputs("timeout_recover", 3'd0, 8'h55, 8'hAA);

        // reset in the middle of the second byte
        c0 = cnt_cmd;
        send_byte(8'hA7, 1'b0, 1'b0, -1);
        send_byte(8'h44, 1'b0, 1'b0, 3);
        check_outputs("reset_outputs", 3'd0, 8'h00, 8'h00);
        check("reset_no_cmd", cnt_cmd - c0, 0);
        idle_bits(2);
        send_byte(8'hA1, 1'b0, 1'b0, -1);
        send_byte(8'h01, 1'b0, 1'b0, -1);
        send_byte(8'h02, 1'b0, 1'b0, -1);
        idle_bits(2);
        check_outputs("reset_recover", 3'd1, 8'h01, 8'h02);

`ifdef UART_CMD_RX_PARITY_EN
        // parity error on the header
        f0 = cnt_ferr;
        send_byte(8'hA6, 1'b0, 1'b1, -1);
        idle_bits(2);
        check("parity_ferr", cnt_ferr - f0, 1);
        send_byte(8'hA6, 1'b0, 1'b0, -1);
        send_byte(8'h08, 1'b0, 1'b0, -1);
        send_byte(8'h09, 1'b0, 1'b0, -1);
        idle_bits(2);
        check_outputs("parity_recover", 3'd6, 8'h08, 8'h09);
`endif

        // randomized byte stream
        for (int n = 0; n < 150; n++) begin
            if (pos == 0 && $urandom_range(0, 3) != 0) rd = {5'b10100, 3'($urandom)};
            else                                       rd = 8'($urandom);
            rs = ($urandom_range(0, 19) == 0);
            send_byte(rd, rs, 1'b0, -1);
            r = int'($urandom_range(0, 19));
            if (r == 0)      idle_bits(TMO + int'($urandom_range(0, 8)));
            else if (r < 6)  idle_bits(int'($urandom_range(1, 12)));
        end
        idle_bits(2);
        check("total_cmd_count", cnt_cmd, n_exp_cmd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command receiver on the host side of the ALU datapath. It deserialises 8N1 UART bytes from the `rx` pin and assembles 3-byte command frames (header/opcode, operand A, operand B). It presents them as `opcode`/`a`/`b` with a one-cycle `cmd_valid` strobe, in the same format the ALU/FSM path consumes. It is the receive-side counterpart of the existing UART transmit path and runs at the same bit timing.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 4..65535; must match the TX side.
- `TIMEOUT_BITS`, 32: inter-byte timeout in bit periods while a frame is partially received; 0 disables the timeout.

- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `rx`  in  1: serial input, idle high, asynchronous to `clock`.
- `opcode`  out  3: opcode of the last complete frame.
- `a`  out  8: operand A of the last complete frame.
- `b`  out  8: operand B of the last complete frame.
- `cmd_valid`  out  1: one-cycle pulse; `opcode`/`a`/`b` updated this cycle.
- `rx_busy`  out  1: high while the byte receiver is not in IDLE.
- `frame_err`  out  1: one-cycle pulse on stop-bit error, parity error or timeout.
- `sync_err`  out  1: one-cycle pulse when a header byte has bad sync bits.

## Operation
- Input: `rx` passes through a 2-flop synchroniser before any use. Reset value of the synchroniser flops is 1.
- Byte receiver states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE -> START on synced `rx` = 0.
  - START: wait `CLKS_PER_BIT/2` (integer) cycles, then sample. If the sample is 1, it is a false start: return to IDLE. If 0, go to DATA.
  - DATA: 8 samples, each `CLKS_PER_BIT` cycles apart, taken LSB first.
  - PARITY (macro only): one sample.
  - STOP: one sample. If 1, the byte is good. If 0, pulse `frame_err` and discard the byte. Either way, go to IDLE the cycle after the sample.
- Counters: the bit-timer is wide enough for `CLKS_PER_BIT-1` and reloads to 0 on every sample. The bit index is 3 bits and wraps 7 -> 0.
- Frame assembler states: HDR, OPA, OPB.
  - HDR: a good byte with `byte[7:3]` == 5'b10100 latches `byte[2:0]` into a holding register and goes to OPA. Any other value pulses `sync_err` and stays in HDR.
  - OPA: a good byte latches into the A holding register; go to OPB.
  - OPB: a good byte is B. In the same cycle, copy the holding registers and this byte to `opcode`/`a`/`b`, pulse `cmd_valid`, and go to HDR.
  - Any `frame_err` forces the assembler to HDR.
- Outputs `opcode`/`a`/`b` change only on `cmd_valid` and hold otherwise. Partial frames never disturb them.
- Timeout: applies in OPA/OPB only.
  - The counter counts clock cycles since the last good byte and is cleared by each good byte.
  - When it reaches `TIMEOUT_BITS*CLKS_PER_BIT`, pulse `frame_err` and go to HDR.
  - If a byte completes in the same cycle the timeout fires, the byte wins: no timeout, normal advance.
- Reset values: `opcode`=0, `a`=0, `b`=0, `cmd_valid`=0, `rx_busy`=0, `frame_err`=0, `sync_err`=0. Receiver goes to IDLE, assembler to HDR, all counters to 0.
- Reset mid-byte or mid-frame discards all partial data. After release, reception restarts at the next falling edge of `rx`.

## Timing
- `rx` edge to synchronised value: 2 cycles.
- Start edge (synced) to first data sample: `CLKS_PER_BIT/2 + CLKS_PER_BIT` cycles.
- Stop-bit sample to `cmd_valid` (third byte) or `frame_err`/`sync_err`: 1 cycle, registered.
- The receiver returns to IDLE at mid-stop-bit, so back-to-back bytes with a 1-bit stop and no idle are received without loss.
- The block has no backpressure. A consumer must take the outputs on `cmd_valid`; they stay stable until the next frame completes, which is at least 30 bit periods later.

## Configuration
- `UART_CMD_RX_PARITY_EN` defined: frame is 8E1. An even-parity bit follows D7. On mismatch, pulse `frame_err`, discard the byte and force HDR. The stop bit is still sampled and checked.
- Not defined: frame is 8N1. The PARITY state and its logic are absent.

## Test plan
- Valid frame: `CLKS_PER_BIT`=16, send 0xA3, 0x12, 0x34 back-to-back. Expect exactly one `cmd_valid` pulse with `opcode`=3, `a`=0x12, `b`=0x34, and no error pulses.
- Bad sync: send 0x55, then 0xA5, 0xFF, 0x01. Expect one `sync_err` on the first byte, then `cmd_valid` with `opcode`=5, `a`=0xFF, `b`=0x01.
- Framing error: send 0xA1, then 0x22 with stop bit forced 0, then 0xA2, 0x10, 0x20. Expect `frame_err` once and a single `cmd_valid` with `opcode`=2, `a`=0x10, `b`=0x20. Outputs hold the old values until then.
- Glitch and timeout: drive `rx` low for 4 cycles and expect no byte and `rx_busy` back low. Then send 0xA4 and 0x33 and wait 32×16 cycles. Expect `frame_err`, then a new frame is accepted normally.
- Reset mid-frame: send 0xA7, then 0x44 with reset asserted at data bit 3. Expect all outputs 0 and no `cmd_valid`. The next full frame 0xA1, 0x01, 0x02 yields `opcode`=1, `a`=1, `b`=2.
- Parity (macro defined): send 0xA6 with wrong parity. Expect `frame_err` and the assembler stays in HDR. A correct-parity 0xA6, 0x08, 0x09 then yields `cmd_valid`.
